// File: rtl/modport_bridge_pkg.sv
// Shared encodings, FSM states and the address map for the AHB-Lite to APB bridge.
// The decode function maps an AHB address to a one-hot APB select or a decode error.
package modport_bridge_pkg;

    localparam int ADDR_W_P  = 32;
    localparam int DATA_W_P  = 32;
    localparam int NUM_SLV_P = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ENABLE = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    localparam logic [ADDR_W_P-1:0] REG0_BASE  = 32'h8000_0000;
    localparam logic [ADDR_W_P-1:0] REG0_LIMIT = 32'h83FF_FFFF;
    localparam logic [ADDR_W_P-1:0] REG1_BASE  = 32'h8400_0000;
    localparam logic [ADDR_W_P-1:0] REG1_LIMIT = 32'h87FF_FFFF;
    localparam logic [ADDR_W_P-1:0] REG2_BASE  = 32'h8800_0000;
    localparam logic [ADDR_W_P-1:0] REG2_LIMIT = 32'h8BFF_FFFF;

    typedef struct packed {
        logic                 err;
        logic [NUM_SLV_P-1:0] sel;
    } decode_t;

    function automatic decode_t decode_addr(input logic [ADDR_W_P-1:0] addr);
        decode_t d;
        d.err = 1'b0;
        d.sel = 3'b000;
        if ((addr >= REG0_BASE) && (addr <= REG0_LIMIT)) begin
            d.sel = 3'b001;
        end else if ((addr >= REG1_BASE) && (addr <= REG1_LIMIT)) begin
            d.sel = 3'b010;
        end else if ((addr >= REG2_BASE) && (addr <= REG2_LIMIT)) begin
            d.sel = 3'b100;
        end else begin
            d.err = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/modport_bridge_ahb_if.sv
// AHB-Lite address-phase front end: detects valid transfers, decodes the address
// and captures address, direction and select for the APB side.
module modport_bridge_ahb_if
    import modport_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hsel,
    input  logic [1:0]         htrans,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic               hwrite,
    input  logic               hready,
    output logic               xfer_valid_s,
    output logic               xfer_err_s,
    output logic [ADDR_W-1:0]  addr_r,
    output logic               write_r,
    output logic [NUM_SLV-1:0] sel_r
);

    decode_t dec_s;

    // Transfer qualification and address decode for the current address phase.
    always_comb begin
        dec_s        = decode_addr(haddr);
        xfer_valid_s = hsel & htrans[1] & hready;
        xfer_err_s   = dec_s.err;
    end

    // Capture control on every accepted transfer; held through the APB access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= '0;
            write_r <= 1'b0;
            sel_r   <= '0;
        end else if (xfer_valid_s) begin
            addr_r  <= haddr;
            write_r <= hwrite;
            sel_r   <= dec_s.sel;
        end
    end

endmodule

// File: rtl/modport_bridge.sv
// AHB-Lite slave to APB master bridge: each accepted AHB transfer becomes one fixed
// SETUP+ENABLE APB access; unmapped addresses get a two-cycle ERROR response.
module modport_bridge
    import modport_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3
) (
    input  logic               clk,
    input  logic               HRESETn,
    input  logic               HSELAHB,
    input  logic [ADDR_W-1:0]  HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [DATA_W-1:0]  HWDATA,
    output logic [DATA_W-1:0]  HRDATA,
    output logic               HREADY,
    output logic               HRESP,
    output logic [ADDR_W-1:0]  PADDR,
    output logic [DATA_W-1:0]  PWDATA,
    input  logic [DATA_W-1:0]  PRDATA,
    output logic               PWRITE,
    output logic [NUM_SLV-1:0] PSELx,
    output logic               PENABLE
);

    state_e               state_r;
    state_e               state_s;
    logic                 xfer_valid_s;
    logic                 xfer_err_s;
    logic [ADDR_W-1:0]    addr_r;
    logic                 write_r;
    logic [NUM_SLV-1:0]   sel_r;
    logic [DATA_W-1:0]    pwdata_r;

    modport_bridge_ahb_if #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV)
    ) u_ahb_if (
        .clk          (clk),
        .rst_n        (HRESETn),
        .hsel         (HSELAHB),
        .htrans       (HTRANS),
        .haddr        (HADDR),
        .hwrite       (HWRITE),
        .hready       (HREADY),
        .xfer_valid_s (xfer_valid_s),
        .xfer_err_s   (xfer_err_s),
        .addr_r       (addr_r),
        .write_r      (write_r),
        .sel_r        (sel_r)
    );

    // FSM state register; reset aborts any in-flight APB access.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: IDLE, ENABLE and ERR2 all accept the next (pipelined) address phase.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_ENABLE, ST_ERR2: begin
                if (xfer_valid_s) begin
                    if (xfer_err_s) begin
                        state_s = ST_ERR1;
                    end else if (HWRITE) begin
                        state_s = ST_WWAIT;
                    end else begin
                        state_s = ST_SETUP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WWAIT: state_s = ST_SETUP;
            ST_SETUP: state_s = ST_ENABLE;
            ST_ERR1:  state_s = ST_ERR2;
            default:  state_s = ST_IDLE;
        endcase
    end

    // AHB response and APB strobes decoded from the current state.
    always_comb begin
        HREADY  = 1'b1;
        HRESP   = HRESP_OKAY;
        HRDATA  = '0;
        PSELx   = '0;
        PENABLE = 1'b0;
        case (state_r)
            ST_IDLE: begin
                HREADY = 1'b1;
            end
            ST_WWAIT: begin
                HREADY = 1'b0;
            end
            ST_SETUP: begin
                HREADY = 1'b0;
                PSELx  = sel_r;
            end
            ST_ENABLE: begin
                HREADY  = 1'b1;
                PSELx   = sel_r;
                PENABLE = 1'b1;
                if (!write_r) begin
                    HRDATA = PRDATA;
                end else begin
                    HRDATA = '0;
                end
            end
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = HRESP_ERROR;
            end
            ST_ERR2: begin
                HREADY = 1'b1;
                HRESP  = HRESP_ERROR;
            end
            default: begin
                HREADY = 1'b1;
            end
        endcase
    end

    // Write data arrives in the AHB data phase, captured during the write wait state.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            pwdata_r <= '0;
        end else if (state_r == ST_WWAIT) begin
            pwdata_r <= HWDATA;
        end
    end

    assign PADDR  = addr_r;
    assign PWRITE = write_r;
    assign PWDATA = pwdata_r;

endmodule

// File: tb/tb_modport_bridge.sv
// Directed bench for modport_bridge: expected APB accesses and error responses are
// queued at address phase and checked by a monitor when the bridge completes them.
module tb_modport_bridge;

    logic        clk;
    logic        HRESETn;
    logic        HSELAHB;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PWRITE;
    logic [2:0]  PSELx;
    logic        PENABLE;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sel;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [31:0] b_addr [5] = '{32'h83FF_FFFC, 32'h8400_0000, 32'h8BFF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFC};
    logic [2:0]  b_sel  [5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    logic        b_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    modport_bridge dut (
        .clk     (clk),
        .HRESETn (HRESETn),
        .HSELAHB (HSELAHB),
        .HADDR   (HADDR),
        .HTRANS  (HTRANS),
        .HWRITE  (HWRITE),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .HREADY  (HREADY),
        .HRESP   (HRESP),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PWRITE  (PWRITE),
        .PSELx   (PSELx),
        .PENABLE (PENABLE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] sel, input logic err);
        exp_t e;
        e.wr = wr; e.addr = addr; e.data = data; e.sel = sel; e.err = err;
        exp_q.push_back(e);
    endtask

    // Entered at an HREADY=1 cycle; returns at the negedge of the last data-phase cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] sel, input logic err);
        int waits;
        HSELAHB = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
        push(wr, addr, data, sel, err);
        cyc();
        HTRANS = 2'b00; HWDATA = data; PRDATA = data;
        waits = 0;
        @(negedge clk);
        while ((HREADY !== 1'b1) && (waits < 8)) begin
            waits++;
            cyc();
            @(negedge clk);
        end
        chk("wait_states", waits, (err || !wr) ? 32'd1 : 32'd2);
    endtask

    // Scoreboard monitor: every APB ENABLE and every final ERROR cycle consumes one entry.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (HRESETn === 1'b1 && PENABLE === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_penable", {31'd0, PENABLE}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("en_not_err", {31'd0, e.err}, 32'd0);
                chk("en_psel", {29'd0, PSELx}, {29'd0, e.sel});
                chk("en_paddr", PADDR, e.addr);
                chk("en_pwrite", {31'd0, PWRITE}, {31'd0, e.wr});
                chk("en_hready", {31'd0, HREADY}, 32'd1);
                chk("en_hresp", {31'd0, HRESP}, 32'd0);
                if (e.wr) chk("en_pwdata", PWDATA, e.data);
                else      chk("en_hrdata", HRDATA, e.data);
            end
        end else if (HRESETn === 1'b1 && HRESP === 1'b1 && HREADY === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_error", {31'd0, HRESP}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("err_expected", {31'd0, e.err}, 32'd1);
                chk("err_psel", {29'd0, PSELx}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; HSELAHB = 1'b0; HADDR = '0; HTRANS = 2'b00;
        HWRITE = 1'b0; HWDATA = '0; PRDATA = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hready", {31'd0, HREADY}, 32'd1);
        chk("rst_hresp", {31'd0, HRESP}, 32'd0);
        chk("rst_psel", {29'd0, PSELx}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        cyc();
        HRESETn = 1'b1;
        cyc();

        // Single write, stepped cycle by cycle.
        HSELAHB = 1'b1; HTRANS = 2'b10; HADDR = 32'h8000_0010; HWRITE = 1'b1;
        push(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b001, 1'b0);
        @(negedge clk); chk("wr_addr_hready", {31'd0, HREADY}, 32'd1);
        cyc(); HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
        @(negedge clk); chk("wr_wwait_hready", {31'd0, HREADY}, 32'd0);
        chk("wr_wwait_psel", {29'd0, PSELx}, 32'd0);
        cyc(); HWDATA = 32'h0BAD_0BAD;
        @(negedge clk); chk("wr_setup_hready", {31'd0, HREADY}, 32'd0);
        chk("wr_setup_psel", {29'd0, PSELx}, 32'd1);
        chk("wr_setup_penable", {31'd0, PENABLE}, 32'd0);
        cyc();
        @(negedge clk); chk("wr_enable_hready", {31'd0, HREADY}, 32'd1);
        chk("wr_enable_hrdata", HRDATA, 32'd0);
        cyc();
        @(negedge clk); chk("wr_idle_psel", {29'd0, PSELx}, 32'd0);
        chk("wr_idle_penable", {31'd0, PENABLE}, 32'd0);
        chk("wr_pwdata_hold", PWDATA, 32'hDEAD_BEEF);

        // Single read and a decode error.
        cyc();
        xfer(1'b0, 32'h8400_0004, 32'h1234_5678, 3'b010, 1'b0);
        chk("rd_hrdata", HRDATA, 32'h1234_5678);
        cyc();
        @(negedge clk); chk("rd_idle_hrdata", HRDATA, 32'd0);
        cyc();
        HSELAHB = 1'b1; HTRANS = 2'b10; HADDR = 32'h9000_0000; HWRITE = 1'b0;
        push(1'b0, 32'h9000_0000, 32'd0, 3'b000, 1'b1);
        cyc(); HTRANS = 2'b00;
        @(negedge clk); chk("err1_hready", {31'd0, HREADY}, 32'd0);
        chk("err1_hresp", {31'd0, HRESP}, 32'd1);
        chk("err1_psel", {29'd0, PSELx}, 32'd0);
        cyc();
        @(negedge clk); chk("err2_hready", {31'd0, HREADY}, 32'd1);
        chk("err2_hresp", {31'd0, HRESP}, 32'd1);
        cyc();
        @(negedge clk); chk("err_idle_hresp", {31'd0, HRESP}, 32'd0);

        // BUSY and deselected transfers must not start an APB access.
        cyc();
        HTRANS = 2'b01; HADDR = 32'h8000_0000;
        cyc();
        HSELAHB = 1'b0; HTRANS = 2'b10;
        @(negedge clk); chk("busy_hready", {31'd0, HREADY}, 32'd1);
        chk("busy_psel", {29'd0, PSELx}, 32'd0);
        cyc();
        HSELAHB = 1'b1; HTRANS = 2'b00;
        @(negedge clk); chk("unsel_psel", {29'd0, PSELx}, 32'd0);
        chk("unsel_hready", {31'd0, HREADY}, 32'd1);

        // Address-map boundaries, alternating write/read.
        for (int i = 0; i < 5; i++) begin
            cyc();
            xfer(i[0], b_addr[i], 32'hC0DE_0000 + i, b_sel[i], b_err[i]);
        end

        // Back-to-back: read address phase overlaps the write's ENABLE.
        cyc();
        HSELAHB = 1'b1; HTRANS = 2'b10; HADDR = 32'h8800_0000; HWRITE = 1'b1;
        push(1'b1, 32'h8800_0000, 32'hA5A5_0F0F, 3'b100, 1'b0);
        cyc(); HTRANS = 2'b00; HWDATA = 32'hA5A5_0F0F;
        cyc();
        @(negedge clk); chk("b2b_wr_setup_psel", {29'd0, PSELx}, 32'd4);
        cyc();
        HTRANS = 2'b10; HADDR = 32'h8000_0000; HWRITE = 1'b0; PRDATA = 32'hCAFE_F00D;
        push(1'b0, 32'h8000_0000, 32'hCAFE_F00D, 3'b001, 1'b0);
        @(negedge clk); chk("b2b_wr_enable_psel", {29'd0, PSELx}, 32'd4);
        chk("b2b_wr_enable_pen", {31'd0, PENABLE}, 32'd1);
        cyc(); HTRANS = 2'b00;
        @(negedge clk); chk("b2b_rd_setup_psel", {29'd0, PSELx}, 32'd1);
        chk("b2b_rd_setup_pen", {31'd0, PENABLE}, 32'd0);
        chk("b2b_rd_setup_hready", {31'd0, HREADY}, 32'd0);
        cyc();
        @(negedge clk); chk("b2b_rd_hrdata", HRDATA, 32'hCAFE_F00D);

        // Reset during the SETUP cycle of a write.
        cyc();
        HTRANS = 2'b10; HADDR = 32'h8000_0020; HWRITE = 1'b1;
        push(1'b1, 32'h8000_0020, 32'h1111_2222, 3'b001, 1'b0);
        cyc(); HTRANS = 2'b00; HWDATA = 32'h1111_2222;
        cyc();
        @(negedge clk); chk("mid_setup_psel", {29'd0, PSELx}, 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_rst_psel", {29'd0, PSELx}, 32'd0);
        chk("mid_rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("mid_rst_hready", {31'd0, HREADY}, 32'd1);
        chk("mid_rst_pwdata", PWDATA, 32'd0);
        chk("mid_rst_pwrite", {31'd0, PWRITE}, 32'd0);
        exp_q.delete();
        cyc(); cyc();
        HRESETn = 1'b1;
        cyc();
        xfer(1'b0, 32'h8000_0000, 32'h5A5A_A5A5, 3'b001, 1'b0);
        cyc();
        cyc();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
